alu_issue_stage: RTL

- Producer side of the ALU operand interface: decodes RV32I ALU-class instructions and drives the registered operand A, operand B and 4-bit ALU op into the execute stage.
- Sits between the register-file read (decode) and the ALU, forming the ID/EX pipeline register.
- Uses valid/ready on both sides with a one-entry skid buffer, giving full throughput under backpressure.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_issue_stage_if.sv | 30 +++
 rtl/alu_decode.sv | 104 ++++++++++
 rtl/alu_issue_stage.sv | 80 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU issue-stage shared types: op codes, RV32I opcode constants and the operand bundle.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OP_W-1:0] op;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } bundle_t;

  // Op selected by funct3 for the base (funct7 = 0000000) encodings.
  function automatic logic [OP_W-1:0] f3_op(input logic [2:0] f3);
    logic [OP_W-1:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute handshake bus; master = issue stage, slave = its environment.
interface alu_issue_stage_if #(parameter int XLEN = alu_pkg::XLEN);

  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               instr;
  logic [XLEN-1:0]           pc;
  logic [XLEN-1:0]           rs1_data;
  logic [XLEN-1:0]           rs2_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           alu_a;
  logic [XLEN-1:0]           alu_b;
  logic [alu_pkg::OP_W-1:0]  alu_op;
  logic [4:0]                rd;
  logic                      wb_en;
  logic                      illegal;

  modport master (
    input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rd, wb_en, illegal
  );

  modport slave (
    output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, wb_en, illegal
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decoder: instruction + operands in, operand bundle out.
// Illegal encodings yield a = b = 0, op ADD, wb_en = 0, illegal = 1.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]   i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output bundle_t       o_bundle
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [OP_W-1:0] w_op;
  logic            w_legal;

  assign w_opc   = i_instr[6:0];
  assign w_rd    = i_instr[11:7];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_shamt = {{(XLEN-5){1'b0}}, i_instr[24:20]};

  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_op    = ALU_ADD;
    w_legal = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_a = i_rs1_data;
        w_b = i_rs2_data;
        case (w_f3)
          3'b000: begin
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            w_op    = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          end
          3'b101: begin
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            w_op    = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          default: begin
            w_legal = (w_f7 == F7_BASE);
            w_op    = f3_op(w_f3);
          end
        endcase
      end
      OPC_OPIMM: begin
        w_a = i_rs1_data;
        w_b = w_imm_i;
        case (w_f3)
          3'b001: begin
            w_b     = w_shamt;
            w_legal = (w_f7 == F7_BASE);
            w_op    = ALU_SLL;
          end
          3'b101: begin
            w_b     = w_shamt;
            w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            w_op    = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          default: begin
            // funct7 bits are immediate here, so every other funct3 is legal.
            w_legal = 1'b1;
            w_op    = f3_op(w_f3);
          end
        endcase
      end
      OPC_LUI: begin
        w_b     = w_imm_u;
        w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_a     = i_pc;
        w_b     = w_imm_u;
        w_legal = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_bundle    = '0;
    o_bundle.rd = w_rd;
    if (w_legal) begin
      o_bundle.a     = w_a;
      o_bundle.b     = w_b;
      o_bundle.op    = w_op;
      o_bundle.wb_en = (w_rd != 5'd0);
    end else begin
      o_bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register with one-entry skid: latency 1, full throughput; in_ready drops only when the skid holds data.
// ALU_ISSUE_ILLEGAL_TRAP_EN: illegal encodings flow as trap bundles; otherwise they are dropped and illegal reads 0.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_stage_if.master    bus
);

  bundle_t w_dec;
  bundle_t w_new;
  logic    w_keep;
  logic    w_acc;
  logic    w_main_free;

  bundle_t r_main;
  bundle_t r_skid;
  logic    r_main_vld;
  logic    r_skid_vld;

  alu_decode u_decode (
    .i_instr    (bus.instr),
    .i_pc       (bus.pc),
    .i_rs1_data (bus.rs1_data),
    .i_rs2_data (bus.rs2_data),
    .o_bundle   (w_dec)
  );

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign w_keep = 1'b1;
  assign w_new  = w_dec;
`else
  assign w_keep = !w_dec.illegal;
  always_comb begin
    w_new         = w_dec;
    w_new.illegal = 1'b0;
  end
`endif

  assign bus.in_ready = !r_skid_vld;
  assign w_acc        = bus.in_valid && !r_skid_vld && !bus.flush && w_keep;
  assign w_main_free  = !r_main_vld || bus.out_ready;

  // A full skid implies in_ready = 0, so a skid->main move never races a new accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (bus.flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_main_vld <= w_acc;
        if (w_acc) begin
          r_main <= w_new;
        end
      end
    end else if (w_acc) begin
      r_skid     <= w_new;
      r_skid_vld <= 1'b1;
    end
  end

  assign bus.out_valid = r_main_vld;
  assign bus.alu_a     = r_main.a;
  assign bus.alu_b     = r_main.b;
  assign bus.alu_op    = r_main.op;
  assign bus.rd        = r_main.rd;
  assign bus.wb_en     = r_main.wb_en;
  assign bus.illegal   = r_main.illegal;

endmodule
